// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage RV32I pipeline: MEM/WB register, load extraction,
// writeback select, register-file write port, forwarding source and retire counter.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [2:0]      mem_funct3,
  input  logic            stall,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_misaligned,
  output logic [XLEN-1:0] retire_count
);

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] retire_q, retire_d;

  logic [1:0]      offset;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_val;
  logic            half_op, word_op, misaligned, live;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    wb_sel_d    = wb_sel_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    ld_d        = ld_q;
    funct3_d    = funct3_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      rd_d        = mem_rd;
      wb_sel_d    = mem_wb_sel;
      alu_d       = mem_alu_result;
      pc4_d       = mem_pc_plus4;
      ld_d        = mem_load_data;
      funct3_d    = mem_funct3;
    end
  end

  always_comb begin
    offset = alu_q[1:0];
    case (offset)
      2'd0:    ld_byte = ld_q[7:0];
      2'd1:    ld_byte = ld_q[15:8];
      2'd2:    ld_byte = ld_q[23:16];
      default: ld_byte = ld_q[31:24];
    endcase
    ld_half = offset[1] ? ld_q[31:16] : ld_q[15:0];
    case (funct3_q)
      3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
      default: load_val = ld_q;
    endcase
    // funct3[1] set covers lw and the unused encodings, all treated as full-word
    half_op    = (funct3_q[1:0] == 2'b01);
    word_op    = funct3_q[1];
    misaligned = (wb_sel_q == 2'b01) &&
                 ((half_op && offset[0]) || (word_op && (offset != 2'b00)));
    case (wb_sel_q)
      2'b01:   wb_val = load_val;
      2'b10:   wb_val = pc4_q;
      default: wb_val = alu_q;
    endcase
  end

  always_comb begin
    live            = valid_q && reg_write_q && (rd_q != 5'd0) && !misaligned;
    rf_we           = live && !stall;
    rf_rd           = rd_q;
    rf_wdata        = wb_val;
    fwd_valid       = live;
    fwd_rd          = rd_q;
    fwd_data        = wb_val;
    load_misaligned = valid_q && misaligned && !stall;
    retire_count    = retire_q;
    retire_d        = retire_q;
    if (valid_q && !stall && !misaligned) begin
      retire_d = retire_q + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_sel_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      ld_q        <= '0;
      funct3_q    <= '0;
      retire_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_sel_q    <= wb_sel_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      ld_q        <= ld_d;
      funct3_q    <= funct3_d;
      retire_q    <= retire_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random traffic,
// compared against an arithmetic model of the writeback rules.
module tb_wb_stage;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic [2:0]  f3;
  } ins_t;

  logic        clk, rst;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data;
  logic [2:0]  mem_funct3;
  logic        stall, flush;
  logic        rf_we, fwd_valid, load_misaligned;
  logic [4:0]  rf_rd, fwd_rd;
  logic [31:0] rf_wdata, fwd_data, retire_count;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  ins_t        m;
  logic [31:0] m_cnt;
  bit          m_known;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_pc_plus4(mem_pc_plus4), .mem_load_data(mem_load_data),
    .mem_funct3(mem_funct3), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .load_misaligned(load_misaligned), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] load_value(input ins_t i);
    logic [31:0] b, h;
    b = (i.ld >> (8 * (i.alu % 4))) & 32'hFF;
    h = (i.ld >> (16 * ((i.alu % 4) / 2))) & 32'hFFFF;
    case (i.f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return i.ld;
    endcase
  endfunction

  function automatic bit is_mis(input ins_t i);
    int unsigned a;
    bit half, word;
    a    = i.alu % 4;
    half = (i.f3 == 3'd1) || (i.f3 == 3'd5);
    word = !half && (i.f3 != 3'd0) && (i.f3 != 3'd4);
    return (i.sel == 2'd1) && ((half && (a % 2 == 1)) || (word && a != 0));
  endfunction

  function automatic logic [31:0] wb_value(input ins_t i);
    if (i.sel == 2'd1) return load_value(i);
    if (i.sel == 2'd2) return i.pc4;
    return i.alu;
  endfunction

  task automatic check_all(input bit st);
    bit live;
    live = m.valid && m.rw && (m.rd != 0) && !is_mis(m);
    chk("rf_we", 32'(rf_we), 32'(live && !st));
    chk("fwd_valid", 32'(fwd_valid), 32'(live));
    chk("load_misaligned", 32'(load_misaligned), 32'(m.valid && is_mis(m) && !st));
    chk("retire_count", retire_count, m_cnt);
    if (m_known) begin
      chk("rf_rd", 32'(rf_rd), 32'(m.rd));
      chk("rf_wdata", rf_wdata, wb_value(m));
      chk("fwd_rd", 32'(fwd_rd), 32'(m.rd));
      chk("fwd_data", fwd_data, wb_value(m));
    end
  endtask

  task automatic model_reset();
    m       = '0;
    m_cnt   = '0;
    m_known = 1'b1;
  endtask

  task automatic cycle(input ins_t i, input bit st, input bit fl);
    @(negedge clk);
    mem_valid      = i.valid;
    mem_reg_write  = i.rw;
    mem_rd         = i.rd;
    mem_wb_sel     = i.sel;
    mem_alu_result = i.alu;
    mem_pc_plus4   = i.pc4;
    mem_load_data  = i.ld;
    mem_funct3     = i.f3;
    stall          = st;
    flush          = fl;
    #1;
    check_all(st);
    @(posedge clk);
    if (m.valid && !st && !is_mis(m)) m_cnt = m_cnt + 1;
    if (fl) begin
      m.valid = 1'b0;
      m_known = 1'b0;
    end else if (!st) begin
      m       = i;
      m_known = 1'b1;
    end
  endtask

  function automatic ins_t mk(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3);
    ins_t i;
    i.valid = 1'b1; i.rw = rw; i.rd = rd; i.sel = sel;
    i.alu = alu; i.pc4 = 32'h0000_4004; i.ld = ld; i.f3 = f3;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    logic [2:0] legal [5];
    legal   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    i.valid = ($urandom_range(0, 9) != 0);
    i.rw    = ($urandom_range(0, 3) != 0);
    i.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.sel   = 2'($urandom_range(0, 3));
    i.alu   = $urandom;
    i.pc4   = $urandom;
    i.ld    = $urandom;
    i.f3    = legal[$urandom_range(0, 4)];
    return i;
  endfunction

  initial begin
    ins_t bubble, tmp;
    logic [31:0] c0;
    int unsigned guard;
    bubble = '0;
    rst = 1'b1;
    mem_valid = 0; mem_reg_write = 0; mem_rd = '0; mem_wb_sel = '0;
    mem_alu_result = '0; mem_pc_plus4 = '0; mem_load_data = '0; mem_funct3 = '0;
    stall = 0; flush = 0;
    model_reset();
    #12;
    check_all(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // lb at offset 3
    cycle(mk(1, 5'd3, 2'd1, 32'h0000_1003, 32'h80FF_7F01, 3'd0), 0, 0);
    #1;
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_we", 32'(rf_we), 32'd1);
    c0 = m_cnt;
    cycle(bubble, 0, 0);
    #1;
    chk("lb_retire", retire_count, c0 + 1);

    // lhu then lh at offset 2
    cycle(mk(1, 5'd4, 2'd1, 32'h0000_2002, 32'h8001_1234, 3'd5), 0, 0);
    #1;
    chk("lhu_wdata", rf_wdata, 32'h0000_8001);
    cycle(mk(1, 5'd4, 2'd1, 32'h0000_2002, 32'h8001_1234, 3'd1), 0, 0);
    #1;
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);

    // misaligned lw
    cycle(mk(1, 5'd6, 2'd1, 32'h0000_1002, 32'hDEAD_BEEF, 3'd2), 0, 0);
    c0 = m_cnt;
    #1;
    chk("lw_mis_we", 32'(rf_we), 32'd0);
    chk("lw_mis_fwd", 32'(fwd_valid), 32'd0);
    chk("lw_mis_pulse", 32'(load_misaligned), 32'd1);
    cycle(bubble, 0, 0);
    #1;
    chk("lw_mis_pulse_end", 32'(load_misaligned), 32'd0);
    chk("lw_mis_retire", retire_count, c0);

    // ALU write held by a 3-cycle stall
    cycle(mk(1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 3'd0), 0, 0);
    c0 = m_cnt;
    for (int k = 0; k < 3; k++) cycle(rand_ins(), 1, 0);
    chk("stall_retire_hold", retire_count, c0);
    cycle(bubble, 0, 0);
    #1;
    chk("stall_release_count", retire_count, c0 + 1);

    // rd=0 retires without writing; then flush+stall discards
    cycle(mk(1, 5'd0, 2'd0, 32'h0000_0055, 32'h0, 3'd0), 0, 0);
    #1;
    chk("rd0_we", 32'(rf_we), 32'd0);
    chk("rd0_fwd", 32'(fwd_valid), 32'd0);
    c0 = m_cnt;
    cycle(mk(1, 5'd7, 2'd0, 32'h0000_0077, 32'h0, 3'd0), 0, 0);
    cycle(rand_ins(), 1, 1);
    cycle(bubble, 0, 0);
    #1;
    chk("flush_count", retire_count, c0 + 1);

    // async reset mid-stall at retire_count == 7
    guard = 0;
    while (m_cnt < 7 && guard < 20) begin
      cycle(mk(1, 5'd9, 2'd0, 32'h0000_0099 + guard, 32'h0, 3'd0), 0, 0);
      guard++;
    end
    cycle(rand_ins(), 1, 0);
    @(negedge clk);
    #2;
    chk("pre_reset_count", retire_count, 32'd7);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(1'b1);
    chk("reset_wdata_zero", rf_wdata, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tmp = mk(1, 5'd11, 2'd0, 32'hCAFE_0001, 32'h0, 3'd0);
    cycle(tmp, 0, 0);
    #1;
    chk("post_reset_capture_we", 32'(rf_we), 32'd1);
    chk("post_reset_capture_data", rf_wdata, 32'hCAFE_0001);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      tmp = rand_ins();
      cycle(tmp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    cycle(bubble, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
